// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared constants and encoder state type for the spiking front end
package snn_pkg;

    localparam int NPIX = 25;
    localparam int IW   = 8;
    localparam int AW   = 5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT,
        FIRE,
        DONE
    } enc_state_t;

endpackage

// File: rtl/pixel_spike_encoder_if.sv
// rtl/pixel_spike_encoder_if.sv - host-side write/start bus and pixel/pulse outputs of the encoder
interface pixel_spike_encoder_if;
    import snn_pkg::*;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [IW-1:0]   wr_data;
    logic            start;
    logic [7:0]      num_steps;
    logic [NPIX-1:0] pexel;
    logic            pulse;
    logic            l1_clear;
    logic            busy;
    logic            done;

    modport master (
        output wr_en, wr_addr, wr_data, start, num_steps,
        input  pexel, pulse, l1_clear, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, num_steps,
        output pexel, pulse, l1_clear, busy, done
    );

endinterface

// File: rtl/spike_rate_cell.sv
// rtl/spike_rate_cell.sv - one pixel: intensity register plus carry accumulator
// The spike bit is the carry out of acc + intensity, so it holds between fires.
module spike_rate_cell
    import snn_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [IW-1:0] wr_data,
    input  logic          clr,
    input  logic          fire,
    output logic          spike
);

    logic [IW-1:0] intensity;
    logic [IW-1:0] acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intensity <= '0;
            acc       <= '0;
            spike     <= 1'b0;
        end else begin
            if (wr) begin
                intensity <= wr_data;
            end
            if (clr) begin
                acc   <= '0;
                spike <= 1'b0;
            end else if (fire) begin
                {spike, acc} <= {1'b0, acc} + {1'b0, intensity};
            end
        end
    end

endmodule

// File: rtl/pixel_spike_encoder.sv
// rtl/pixel_spike_encoder.sv - rate-coding encoder: run FSM, timestep pacing, pixel write decode
module pixel_spike_encoder
    import snn_pkg::*;
#(
    parameter int STEP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_spike_encoder_if.slave  bus
);

    localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 2);

    enc_state_t      state;
    logic [CW-1:0]   cyc_cnt;
    logic [7:0]      step_cnt;
    logic [7:0]      steps_lat;
    logic            pulse_r;
    logic            l1_clear_r;
    logic            busy_r;
    logic            done_r;
    logic            wr_ok;
    logic            clr;
    logic            fire;
    logic [NPIX-1:0] pexel_w;

    assign wr_ok = bus.wr_en && !busy_r && (bus.wr_addr < AW'(NPIX));
    // Cells update on the edge that enters CLEAR/FIRE so pexel lines up with l1_clear/pulse.
    assign clr   = (state == IDLE) && bus.start;
    assign fire  = (state == WAIT) && (cyc_cnt == '0);

    for (genvar i = 0; i < NPIX; i++) begin : g_cell
        spike_rate_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_ok && (bus.wr_addr == AW'(i))),
            .wr_data (bus.wr_data),
            .clr     (clr),
            .fire    (fire),
            .spike   (pexel_w[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            step_cnt   <= '0;
            steps_lat  <= '0;
            pulse_r    <= 1'b0;
            l1_clear_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            pulse_r    <= 1'b0;
            l1_clear_r <= 1'b0;
            done_r     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= CLEAR;
                        steps_lat  <= bus.num_steps;
                        l1_clear_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                CLEAR: begin
                    step_cnt <= '0;
                    // CLEAR itself counts as the first cycle of the first timestep.
                    cyc_cnt  <= RELOAD;
                    if (steps_lat == 8'd0) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cyc_cnt == '0) begin
                        state   <= FIRE;
                        pulse_r <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt - CW'(1);
                    end
                end
                FIRE: begin
                    step_cnt <= step_cnt + 8'd1;
                    cyc_cnt  <= RELOAD;
                    if ((step_cnt + 8'd1) == steps_lat) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pexel    = pexel_w;
    assign bus.pulse    = pulse_r;
    assign bus.l1_clear = l1_clear_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule
